// File: rtl/mac_pkg.sv
// Shared defaults and pipeline timing constants for the dot-product MAC controller.
package mac_pkg;

   localparam int unsigned AW_DFLT    = 27;
   localparam int unsigned BW_DFLT    = 18;
   localparam int unsigned PW_DFLT    = 48;
   localparam int unsigned DEPTH_DFLT = 4;

   // Edges from mac_ain capture to mac_pout update in the external mac stage.
   localparam int unsigned MAC_LAT = 4;
   // Delay-line stage whose slot is presented on mac_cin.
   localparam int unsigned CIN_OFS = 3;

endpackage

// File: rtl/res_fifo.sv
// First-word-fall-through result buffer; rd_data is valid whenever rd_valid is high.
module res_fifo #(
   parameter int unsigned PW    = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [PW-1:0]              wr_data,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [PW-1:0]              rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);

   logic [PW-1:0]  mem_q [DEPTH];
   logic [PW-1:0]  mem_d [DEPTH];
   logic [PTW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           valid_q, valid_d;
   logic           push, pop;

   function automatic logic [PTW-1:0] ptr_next(input logic [PTW-1:0] p);
      return (p == PTW'(DEPTH - 1)) ? '0 : p + PTW'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop      = valid_q && rd_ready;
      // A write into a full buffer is only taken when a pop frees a slot on the same edge.
      push     = wr_en && ((count_q < CW'(DEPTH)) || pop);

      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      valid_d = (count_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   assign rd_valid = valid_q;
   assign rd_data  = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/mac_dot_ctrl.sv
// Streams signed operand pairs into an external pipelined MAC and collects one
// wrapped dot-product per vector into a small result buffer.
module mac_dot_ctrl
   import mac_pkg::*;
#(
   parameter int unsigned AW    = AW_DFLT,
   parameter int unsigned BW    = BW_DFLT,
   parameter int unsigned PW    = PW_DFLT,
   parameter int unsigned DEPTH = DEPTH_DFLT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [AW-1:0] s_a,
   input  logic [BW-1:0] s_b,
   input  logic          s_last,
   output logic [AW-1:0] mac_ain,
   output logic [BW-1:0] mac_bin,
   output logic [PW-1:0] mac_cin,
   input  logic [PW-1:0] mac_pout,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [PW-1:0] m_data
);

   localparam int unsigned NSTG = MAC_LAT + 1;
   localparam int unsigned IFW  = $clog2(NSTG + 1);
   localparam int unsigned CW   = $clog2(DEPTH + 1);

   logic                accept;
   logic                wr_en;
   logic [CW-1:0]       fifo_count;

   logic [AW-1:0]       ain_q, ain_d;
   logic [BW-1:0]       b_dly_q, b_dly_d;
   logic [BW-1:0]       bin_q, bin_d;
   logic [CIN_OFS:0]    first_sr_q, first_sr_d;
   logic [MAC_LAT:0]    last_sr_q, last_sr_d;
   logic                first_q, first_d;
   logic [IFW-1:0]      inflight_q, inflight_d;

   // Admission counts both queued results and lasts still travelling the pipe.
   always_comb begin
      s_ready = (32'(inflight_q) + 32'(fifo_count)) < DEPTH;
      accept  = s_valid && s_ready;
   end

   always_comb begin
      ain_d      = accept ? s_a : '0;
      b_dly_d    = accept ? s_b : '0;
      bin_d      = b_dly_q;
      first_sr_d = {first_sr_q[CIN_OFS-1:0], accept && first_q};
      last_sr_d  = {last_sr_q[MAC_LAT-1:0], accept && s_last};
      first_d    = accept ? s_last : first_q;
      wr_en      = last_sr_q[MAC_LAT];
      inflight_d = inflight_q + IFW'(accept && s_last) - IFW'(wr_en);
   end

   // Bubbles carry the running sum forward; only a first beat restarts it.
   always_comb begin
      mac_cin = first_sr_q[CIN_OFS] ? '0 : mac_pout;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ain_q      <= '0;
         b_dly_q    <= '0;
         bin_q      <= '0;
         first_sr_q <= '0;
         last_sr_q  <= '0;
         first_q    <= 1'b1;
         inflight_q <= '0;
      end else begin
         ain_q      <= ain_d;
         b_dly_q    <= b_dly_d;
         bin_q      <= bin_d;
         first_sr_q <= first_sr_d;
         last_sr_q  <= last_sr_d;
         first_q    <= first_d;
         inflight_q <= inflight_d;
      end
   end

   assign mac_ain = ain_q;
   assign mac_bin = bin_q;

   res_fifo #(
      .PW    (PW),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (mac_pout),
      .rd_ready (m_ready),
      .rd_valid (m_valid),
      .rd_data  (m_data),
      .count    (fifo_count)
   );

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Scoreboard bench for mac_dot_ctrl with a behavioural MAC stage and dot-product model.
module tb_mac_dot_ctrl;

   localparam int unsigned AW    = 27;
   localparam int unsigned BW    = 18;
   localparam int unsigned PW    = 48;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [AW-1:0] s_a;
   logic [BW-1:0] s_b;
   logic          s_last;
   logic [AW-1:0] mac_ain;
   logic [BW-1:0] mac_bin;
   logic [PW-1:0] mac_cin;
   logic [PW-1:0] mac_pout;
   logic          m_valid;
   logic          m_ready;
   logic [PW-1:0] m_data;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            n_pop = 0;
   int            stalls = 0;
   logic          rand_ready = 1'b0;
   longint        acc = 0;
   logic [PW-1:0] exp_q [$];

   always #5 clk = ~clk;

   mac_dot_ctrl #(
      .AW (AW), .BW (BW), .PW (PW), .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_a      (s_a),
      .s_b      (s_b),
      .s_last   (s_last),
      .mac_ain  (mac_ain),
      .mac_bin  (mac_bin),
      .mac_cin  (mac_cin),
      .mac_pout (mac_pout),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data)
   );

   // Downstream MAC: A two regs, B one reg, M reg, P = M + C registered.
   logic signed [AW-1:0] a1, a2;
   logic signed [BW-1:0] b1;
   logic signed [PW-1:0] m_r, p_r;
   always @(posedge clk) begin
      a1  <= mac_ain;
      a2  <= a1;
      b1  <= mac_bin;
      m_r <= PW'(a2) * PW'(b1);
      p_r <= m_r + $signed(mac_cin);
   end
   assign mac_pout = p_r;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain running sum per vector, pushed on the last element.
   task automatic send(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic last);
      int w = 0;
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      s_last  = last;
      @(negedge clk);
      while (!s_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (w > 0) stalls++;
      if (!s_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: s_ready %0b expected 1 within 200 cycles", s_ready);
      end else begin
         acc = acc + longint'($signed(a)) * longint'($signed(b));
         if (last) begin
            exp_q.push_back(PW'(acc));
            acc = 0;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      s_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(posedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      idle(3);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      s_last  = 1'b0;
      exp_q.delete();
      acc = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_s_ready", 64'(s_ready), 64'd1);
      check("rst_mac_ain", 64'(mac_ain), 64'd0);
      check("rst_mac_bin", 64'(mac_bin), 64'd0);
      check("rst_mac_cin", 64'(mac_cin), 64'(mac_pout));
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on each handshake and checks hold stability.
   initial begin
      logic [PW-1:0] held = '0;
      logic          hold_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            if (hold_v) begin
               check("m_valid_hold", 64'(m_valid), 64'd1);
               check("m_data_stable", 64'(m_data), 64'(held));
            end
            if (m_valid && m_ready) begin
               n_pop++;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_result: got %0h expected none", m_data);
               end else begin
                  check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
               end
            end
            hold_v = m_valid && !m_ready;
            held   = m_data;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int len;
      m_ready = 1'b1;
      do_reset();

      // Back-to-back [1,2,3].[4,5,6] = 32; m_valid rises 5 edges after the last accept.
      send(27'd1, 18'd4, 1'b0);
      send(27'd2, 18'd5, 1'b0);
      send(27'd3, 18'd6, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("latency_e%0d", k), 64'(m_valid), (k == 5) ? 64'd1 : 64'd0);
      end
      drain();

      // Negative product, sign-extended.
      send(-27'sd3, 18'sd7, 1'b1);
      drain();

      // Bubbles between beats add nothing.
      send(27'd2, 18'd10, 1'b0);
      idle(3);
      send(27'd3, 18'd10, 1'b1);
      drain();

      // Back-pressure: buffer fills after four results.
      m_ready = 1'b0;
      for (int k = 1; k <= 4; k++) send(AW'(k), 18'd1, 1'b1);
      check("bp_ready_low", 64'(s_ready), 64'd0);
      idle(8);
      check("bp_ready_still_low", 64'(s_ready), 64'd0);
      check("bp_m_valid", 64'(m_valid), 64'd1);
      m_ready = 1'b1;
      idle(1);
      m_ready = 1'b0;
      check("bp_ready_after_pop", 64'(s_ready), 64'd1);
      send(27'd5, 18'd1, 1'b1);
      m_ready = 1'b1;
      drain();

      // Reset mid-vector discards the partial sum.
      send(27'd1, 18'd1, 1'b0);
      send(27'd2, 18'd2, 1'b0);
      do_reset();
      p0 = n_pop;
      send(27'd1, 18'd1, 1'b1);
      drain();
      idle(10);
      check("single_result_after_rst", 64'(n_pop - p0), 64'd1);

      // Max-positive operands, continuous readiness.
      stalls = 0;
      for (int v = 0; v < 8; v++) begin
         send(27'h3ff_ffff, 18'h1_ffff, 1'b0);
         send(27'h3ff_ffff, 18'h1_ffff, 1'b1);
      end
      drain();
      check("maxpos_no_stall", 64'(stalls), 64'd0);

      // Random vectors, gaps and output back-pressure.
      rand_ready = 1'b1;
      for (int v = 0; v < 25; v++) begin
         len = int'($urandom_range(1, 4));
         for (int e = 0; e < len; e++) begin
            send(AW'($urandom), BW'($urandom), (e == len - 1));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
         end
      end
      rand_ready = 1'b0;
      m_ready    = 1'b1;
      drain();
      check("final_m_valid", 64'(m_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
